muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the execute stage.
- Serves MULT, MULTU, DIV and DIVU, which the single-cycle ALU cannot perform.
- Runs a 32-step shift-add (multiply) or restoring shift-subtract (divide) loop and owns the HI/LO architectural registers.
- Exposes busy/done to the hazard logic so the pipeline stalls MFHI/MFLO and further mul/div ops while an operation is in flight.

---
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// A WIDTH-step shift-add or restoring shift-subtract loop runs on operand
// magnitudes. The sign correction is applied in a single FIX cycle.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;         // operation is a divide
    logic               neg_q, neg_d;         // negate product / quotient
    logic               neg_rem_q, neg_rem_d; // negate remainder
    logic               div0_q, div0_d;       // divide by zero
    logic [WIDTH-1:0]   a_q, a_d;             // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   mag_q, mag_d;         // multiplicand / divisor magnitude
    logic [ACC_W-1:0]   acc_q, acc_d;         // {upper, lower} working register
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [ACC_W-1:0]   div_next;
    logic [ACC_W-1:0]   prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes, one loop step for each algorithm, and the sign-corrected results.
    always_comb begin
        op_signed  = ~op[0];
        mag_a      = (op_signed && a[WIDTH-1]) ? -a : a;
        mag_b      = (op_signed && b[WIDTH-1]) ? -b : b;

        mul_addend = acc_q[0] ? mag_q : '0;
        mul_sum    = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift  = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, mag_q});
        div_diff   = div_shift - {1'b0, mag_q};
        div_rem    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next   = {div_rem, acc_q[WIDTH-2:0], div_ge};

        prod_fix   = neg_q ? -acc_q : acc_q;
        quo_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = neg_rem_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_d       = a_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A start in the same cycle as MTHI/MTLO drops the write.
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    div_d     = op[1];
                    neg_d     = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = op_signed && a[WIDTH-1];
                    div0_d    = op[1] && (b == '0);
                    a_d       = a;
                    if (op[1]) begin
                        mag_d = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        mag_d = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!div_q) begin
                        hi_d = prod_fix[ACC_W-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            S_DONE: begin
                // MTHI/MTLO in this cycle replace the result just written.
                state_d = S_IDLE;
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_q       <= a_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, MTHI/MTLO priority, abort and reset.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int busy_n, done_n, ovl_n;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op now, then samples every cycle until done (bounded to 40 cycles).
    // The *_at arguments inject a start/abort/MTHI/reset in that cycle after the start edge.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int restart_at, input int abort_at, input int mthi_at,
                          input int reset_at,
                          output int busy_o, output int done_o, output int ovl_o);
        busy_o = 0;
        done_o = 0;
        ovl_o  = 0;
        start  = 1'b1;
        op     = op_i;
        a      = a_i;
        b      = b_i;
        tick();
        start  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_o++;
            if (done) done_o++;
            if (busy && done) ovl_o++;
            if (done) break;
            start = (i == restart_at);
            if (i == restart_at) a = 32'd5;
            abort = (i == abort_at);
            hi_we = (i == mthi_at);
            reset = (i == reset_at);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        hi_we = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        abort = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("multu_busy_cycles", 32'(busy_n), 32'd33);
        check("multu_done_count", 32'(done_n), 32'd1);
        check("multu_overlap", 32'(ovl_n), 32'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        tick();
        check("idle_done_low", 32'(done), 32'd0);

        run_op(MULT, 32'hFFFF_FFFD, 32'd7, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        tick();

        run_op(DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        hi_we = 1'b1;
        wdata = 32'h0000_ABCD;
        tick();
        hi_we = 1'b0;
        check("mthi_in_done_hi", hi, 32'h0000_ABCD);
        check("mthi_in_done_lo", lo, 32'hFFFF_FFFD);

        run_op(DIVU, 32'd100, 32'd0, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("divu0_busy_cycles", 32'(busy_n), 32'd33);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd100);
        tick();

        run_op(DIV, 32'hFFFF_FFF9, 32'd0, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("div0_signed_lo", lo, 32'hFFFF_FFFF);
        check("div0_signed_hi", hi, 32'hFFFF_FFF9);
        tick();

        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);
        tick();

        run_op(DIVU, 32'd100, 32'd7, 10, -1, -1, -1, busy_n, done_n, ovl_n);
        check("restart_busy_cycles", 32'(busy_n), 32'd33);
        check("restart_done_count", 32'(done_n), 32'd1);
        check("restart_lo", lo, 32'd14);
        check("restart_hi", hi, 32'd2);
        tick();

        run_op(MULTU, 32'd3, 32'd5, -1, 20, -1, -1, busy_n, done_n, ovl_n);
        check("abort_busy_cycles", 32'(busy_n), 32'd21);
        check("abort_done_count", 32'(done_n), 32'd0);
        check("abort_busy_end", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd2);
        check("abort_lo", lo, 32'd14);
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        lo_we = 1'b0;
        check("mtlo_idle_lo", lo, 32'h0000_1234);
        check("mtlo_idle_hi", hi, 32'd2);

        wdata = 32'h0000_DEAD;
        run_op(MULTU, 32'd6, 32'd7, -1, -1, 5, -1, busy_n, done_n, ovl_n);
        check("mthi_busy_hi", hi, 32'h0);
        check("mthi_busy_lo", lo, 32'd42);
        tick();

        lo_we = 1'b1;
        wdata = 32'h0000_5555;
        run_op(MULTU, 32'd3, 32'd4, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("start_wins_lo", lo, 32'd12);
        check("start_wins_hi", hi, 32'h0);
        tick();

        run_op(MULTU, 32'd9, 32'd9, -1, -1, -1, 32, busy_n, done_n, ovl_n);
        check("reset_fix_done_count", 32'(done_n), 32'd0);
        check("reset_fix_busy", 32'(busy), 32'd0);
        check("reset_fix_hi", hi, 32'h0);
        check("reset_fix_lo", lo, 32'h0);

        run_op(DIVU, 32'd100, 32'd7, -1, -1, -1, -1, busy_n, done_n, ovl_n);
        check("post_reset_done_count", 32'(done_n), 32'd1);
        check("post_reset_lo", lo, 32'd14);
        check("post_reset_hi", hi, 32'd2);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
